// File: rtl/ic_pkg.sv
// Shared interconnect definitions: request status encodings, default data width
// and the id/count width helpers used by the arbiter and seeker family.
package ic_pkg;

  typedef enum logic [1:0] {
    NO_REQ = 2'd0,
    WAIT   = 2'd1,
    W_ACK  = 2'd2,
    W_DATA = 2'd3
  } req_status_e;

  localparam int DEFAULT_DW = 32;

  // A single master still needs one id bit so the owner queue has a data lane.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rdata_router_if.sv
// Acknowledge and read-data bus seen by one slave's rdata_router.
// The master modport drives commands and slave words; the slave modport is the router side.
interface rdata_router_if
  import ic_pkg::*;
#(
  parameter int N_M = 2,
  parameter int DW  = DEFAULT_DW,
  parameter int SW  = 2
);
  localparam int MID_W = id_width(N_M);

  logic             ack_valid;
  logic [SW-1:0]    ack_slave;
  logic [MID_W-1:0] ack_master;
  logic             rdata_valid;
  logic [DW-1:0]    rdata_in;
  logic [N_M*DW-1:0] rdata;
  logic [N_M-1:0]   data_read;

  modport master (
    output ack_valid, ack_slave, ack_master, rdata_valid, rdata_in,
    input  rdata, data_read
  );

  modport slave (
    input  ack_valid, ack_slave, ack_master, rdata_valid, rdata_in,
    output rdata, data_read
  );
endinterface

// File: rtl/rdata_router_owner_fifo.sv
// owner_fifo: DEPTH x W queue of read owners with registered count and full flag.
// Push while full is accepted only when a pop happens in the same cycle.
module owner_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          full_reg;
  logic          wr_en;
  logic          rd_en;

  assign empty = (count_reg == '0);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full_reg || rd_en);

  always_comb begin
    count_next = count_reg;
    if (wr_en && !rd_en)
      count_next = count_reg + CW'(1);
    else if (rd_en && !wr_en)
      count_next = count_reg - CW'(1);
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = full_reg;

endmodule

// File: rtl/rdata_router.sv
// Per-slave read-data return router: queues read owners in acceptance order and
// steers each slave word to its owner one cycle later. RDATA_HOLD_EN keeps delivered words.
module rdata_router
  import ic_pkg::*;
#(
  parameter int N_M   = 2,
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = 4,
  parameter int SW    = 2,
  parameter int S_NO  = 0,
  localparam int MID_W = id_width(N_M),
  localparam int CW    = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  rdata_router_if.slave bus,
  output logic [CW-1:0] outstanding,
  output logic          full,
  output logic          err_ovf,
  output logic          err_unexp
);

  logic             push_req;
  logic             pop_en;
  logic             fifo_full;
  logic             fifo_empty;
  logic [MID_W-1:0] head_id;
  logic             err_ovf_reg;
  logic             err_unexp_reg;

  assign push_req = bus.ack_valid && (bus.ack_slave == SW'(S_NO));
  // No bypass: a word arriving with an empty queue is never claimed by a same-cycle push.
  assign pop_en   = bus.rdata_valid && !fifo_empty;

  owner_fifo #(
    .DEPTH (DEPTH),
    .W     (MID_W)
  ) u_owner_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (bus.rdata_valid),
    .din   (bus.ack_master),
    .dout  (head_id),
    .count (outstanding),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_reg   <= 1'b0;
      err_unexp_reg <= 1'b0;
    end else begin
      err_ovf_reg   <= push_req && fifo_full && !pop_en;
      err_unexp_reg <= bus.rdata_valid && fifo_empty;
    end
  end

  // Owner ids >= N_M match no lane, so their words are silently dropped.
  generate
    for (genvar gi = 0; gi < N_M; gi++) begin : g_lane
      logic          deliver;
      logic [DW-1:0] slice_reg;
      logic          strobe_reg;

      assign deliver = pop_en && (head_id == MID_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slice_reg  <= '0;
          strobe_reg <= 1'b0;
        end else begin
          strobe_reg <= deliver;
          if (deliver)
            slice_reg <= bus.rdata_in;
`ifndef RDATA_HOLD_EN
          else
            slice_reg <= '0;
`endif
        end
      end

      assign bus.rdata[gi*DW +: DW] = slice_reg;
      assign bus.data_read[gi]      = strobe_reg;
    end
  endgenerate

  assign full      = fifo_full;
  assign err_ovf   = err_ovf_reg;
  assign err_unexp = err_unexp_reg;

endmodule
